// File: rtl/bin_dec_scan_pkg.sv
// Shared types and constants for the bin_dec_scan decoder family.
// Holds the FSM state encoding, mode encodings and the output-width helper.
package bin_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_e;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int out_w(input int in_w);
        return 1 << in_w;
    endfunction

endpackage

// File: rtl/bin_dec_scan_if.sv
// Control/data bundle between a host and bin_dec_scan.
// The host drives code, mode and dwell; the decoder returns the one-hot select and status.
interface bin_dec_scan_if
    import bin_dec_pkg::*;
#(
    parameter int IN_W    = 4,
    parameter int DWELL_W = 8
);
    localparam int OUT_W = out_w(IN_W);

    logic               en;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_code;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   bcode;
    logic [IN_W-1:0]    code;
    logic               out_valid;
    logic               wrap;

    modport master (
        output en, mode, in_valid, in_code, dwell,
        input  in_ready, bcode, code, out_valid, wrap
    );

    modport slave (
        input  en, mode, in_valid, in_code, dwell,
        output in_ready, bcode, code, out_valid, wrap
    );

endinterface

// File: rtl/bin_dec_scan_core.sv
// Combinational IN_W-to-2**IN_W one-hot decoder with enable.
// Built recursively: the MSB steers the enable into one of two half-width decoders.
module bin_dec_core
    import bin_dec_pkg::*;
#(
    parameter int IN_W = 4
) (
    input  logic                    i_en,
    input  logic [IN_W-1:0]         i_in,
    output logic [out_w(IN_W)-1:0]  o_bcode
);

    generate
        if (IN_W == 1) begin : g_leaf
            assign o_bcode = {i_en & i_in[0], i_en & ~i_in[0]};
        end else begin : g_split
            localparam int HALF = out_w(IN_W - 1);

            logic w_en_lo;
            logic w_en_hi;

            assign w_en_lo = i_en & ~i_in[IN_W-1];
            assign w_en_hi = i_en &  i_in[IN_W-1];

            bin_dec_core #(.IN_W(IN_W - 1)) u_lo (
                .i_en    (w_en_lo),
                .i_in    (i_in[IN_W-2:0]),
                .o_bcode (o_bcode[HALF-1:0])
            );

            bin_dec_core #(.IN_W(IN_W - 1)) u_hi (
                .i_en    (w_en_hi),
                .i_in    (i_in[IN_W-2:0]),
                .o_bcode (o_bcode[2*HALF-1:HALF])
            );
        end
    endgenerate

endmodule

// File: rtl/bin_dec_scan.sv
// Registered binary decoder with a handshake DECODE mode and a self-running SCAN mode.
// bcode is always the registered decode of (code, out_valid), so it never glitches.
module bin_dec_scan
    import bin_dec_pkg::*;
#(
    parameter int IN_W    = 4,
    parameter int DWELL_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    bin_dec_scan_if.slave bus
);

    localparam int OUT_W = out_w(IN_W);

    state_e             r_state,     w_state_nxt;
    logic [IN_W-1:0]    r_code,      w_code_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_cnt_nxt;
    logic [DWELL_W-1:0] r_dwell_lim, w_dwell_lim_nxt;
    logic               r_out_valid, w_en_nxt;
    logic               r_wrap,      w_wrap_nxt;
    logic [OUT_W-1:0]   r_bcode,     w_bcode_nxt;
    logic               w_accept;

    assign bus.in_ready = bus.en & (bus.mode == MODE_DECODE) & rst_n;
    assign w_accept     = bus.in_valid & bus.in_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_dwell_lim_nxt = r_dwell_lim;
        w_en_nxt        = r_out_valid;
        w_wrap_nxt      = 1'b0;

        if (!bus.en) begin
            w_state_nxt     = IDLE;
            w_en_nxt        = 1'b0;
            w_dwell_cnt_nxt = '0;
        end else if (bus.mode == MODE_DECODE) begin
            w_dwell_cnt_nxt = '0;
            if (w_accept) begin
                w_code_nxt  = bus.in_code;
                w_en_nxt    = 1'b1;
                w_state_nxt = HOLD;
            end else begin
                // Leaving SCAN freezes the current select; IDLE stays dark.
                w_state_nxt = r_out_valid ? HOLD : IDLE;
            end
        end else if (r_state != SCAN) begin
            w_state_nxt     = SCAN;
            w_en_nxt        = 1'b1;
            w_dwell_cnt_nxt = '0;
            w_dwell_lim_nxt = bus.dwell;
        end else if (r_dwell_cnt == r_dwell_lim) begin
            w_code_nxt      = r_code + IN_W'(1);
            w_dwell_cnt_nxt = '0;
            w_dwell_lim_nxt = bus.dwell;
            w_wrap_nxt      = &r_code;
        end else begin
            w_dwell_cnt_nxt = r_dwell_cnt + DWELL_W'(1);
        end
    end

    bin_dec_core #(.IN_W(IN_W)) u_core (
        .i_en    (w_en_nxt),
        .i_in    (w_code_nxt),
        .o_bcode (w_bcode_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_dwell_cnt <= '0;
            r_dwell_lim <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_bcode     <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all update together at the edge.
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_dwell_lim <= w_dwell_lim_nxt;
            r_out_valid <= w_en_nxt;
            r_wrap      <= w_wrap_nxt;
            r_bcode     <= w_bcode_nxt;
        end
    end

    assign bus.bcode     = r_bcode;
    assign bus.code      = r_code;
    assign bus.out_valid = r_out_valid;
    assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_bin_dec_scan.sv
// Directed bench for bin_dec_scan: DECODE handshake, SCAN dwell/wrap, enable and async reset,
// with IN_W=4 as the main instance and IN_W=2 / IN_W=6 instances for the reset-restart check.
module tb_bin_dec_scan;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    bin_dec_scan_if #(.IN_W(4), .DWELL_W(8)) m4 ();
    bin_dec_scan_if #(.IN_W(2), .DWELL_W(8)) m2 ();
    bin_dec_scan_if #(.IN_W(6), .DWELL_W(8)) m6 ();

    bin_dec_scan #(.IN_W(4), .DWELL_W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(m4));
    bin_dec_scan #(.IN_W(2), .DWELL_W(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(m2));
    bin_dec_scan #(.IN_W(6), .DWELL_W(8)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(m6));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int exp_code;

        rst_n = 1'b1;
        m4.en = 1'b1; m4.mode = 1'b0; m4.in_valid = 1'b0; m4.in_code = '0; m4.dwell = '0;
        m2.en = 1'b0; m2.mode = 1'b0; m2.in_valid = 1'b0; m2.in_code = '0; m2.dwell = '0;
        m6.en = 1'b0; m6.mode = 1'b0; m6.in_valid = 1'b0; m6.in_code = '0; m6.dwell = '0;

        // Reset values, and in_ready held low while reset is asserted
        #1 rst_n = 1'b0;
        #2;
        check("rst_bcode",     64'(m4.bcode), 64'h0);
        check("rst_code",      64'(m4.code), 64'd0);
        check("rst_out_valid", 64'(m4.out_valid), 64'd0);
        check("rst_wrap",      64'(m4.wrap), 64'd0);
        check("rst_in_ready",  64'(m4.in_ready), 64'd0);
        check("rst_bcode_w2",  64'(m2.bcode), 64'h0);
        check("rst_bcode_w6",  64'(m6.bcode), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(m4.in_ready), 64'd1);
        step();
        check("idle_bcode", 64'(m4.bcode), 64'h0);

        // 1: single decode of 9, then hold with valid low
        m4.in_valid = 1'b1; m4.in_code = 4'd9;
        step();
        check("dec9_bcode",     64'(m4.bcode), 64'h0200);
        check("dec9_code",      64'(m4.code), 64'd9);
        check("dec9_out_valid", 64'(m4.out_valid), 64'd1);
        m4.in_valid = 1'b0; m4.in_code = 4'd3;
        step(3);
        check("hold9_bcode", 64'(m4.bcode), 64'h0200);
        check("hold9_code",  64'(m4.code), 64'd9);

        // 2: back-to-back transfers 0, 15, 7
        m4.in_valid = 1'b1; m4.in_code = 4'd0;
        step();
        check("b2b0_bcode", 64'(m4.bcode), 64'h0001);
        check("b2b_in_ready", 64'(m4.in_ready), 64'd1);
        m4.in_code = 4'd15;
        step();
        check("b2b15_bcode", 64'(m4.bcode), 64'h8000);
        check("b2b15_code",  64'(m4.code), 64'd15);
        m4.in_code = 4'd7;
        step();
        check("b2b7_bcode", 64'(m4.bcode), 64'h0080);
        check("b2b7_in_ready", 64'(m4.in_ready), 64'd1);

        // 3: SCAN from code 14 with dwell=2, across the 15 -> 0 wrap
        m4.in_code = 4'd14;
        step();
        check("dec14_bcode", 64'(m4.bcode), 64'h4000);
        m4.in_valid = 1'b0;
        m4.mode = 1'b1; m4.dwell = 8'd2;
        #1;
        check("scan_in_ready", 64'(m4.in_ready), 64'd0);
        for (int i = 0; i < 9; i++) begin
            step();
            exp_code = (14 + i / 3) % 16;
            check($sformatf("dw2_bcode_%0d", i), 64'(m4.bcode), 64'(1) << exp_code);
            check($sformatf("dw2_wrap_%0d", i),  64'(m4.wrap), 64'(i == 6));
        end

        // 4: dwell=0 steps every cycle, wraps every 16; freeze on switch to DECODE
        m4.dwell = 8'd0;
        for (int k = 1; k <= 37; k++) begin
            step();
            check($sformatf("dw0_code_%0d", k), 64'(m4.code), 64'(k % 16));
            check($sformatf("dw0_wrap_%0d", k), 64'(m4.wrap), 64'(k % 16 == 0));
        end
        m4.mode = 1'b0;
        step();
        check("freeze_bcode", 64'(m4.bcode), 64'h0020);
        check("freeze_wrap",  64'(m4.wrap), 64'd0);
        step(2);
        check("freeze_hold_bcode", 64'(m4.bcode), 64'h0020);
        m4.in_valid = 1'b1; m4.in_code = 4'd3;
        step();
        check("after_freeze_bcode", 64'(m4.bcode), 64'h0008);
        m4.in_valid = 1'b0;

        // 5: en=0 in HOLD, in_valid ignored while disabled, then en=0 in SCAN
        m4.en = 1'b0;
        #1;
        check("dis_in_ready_now", 64'(m4.in_ready), 64'd0);
        check("dis_bcode_still",  64'(m4.bcode), 64'h0008);
        m4.in_valid = 1'b1; m4.in_code = 4'd11;
        step();
        check("dis_bcode",     64'(m4.bcode), 64'h0);
        check("dis_out_valid", 64'(m4.out_valid), 64'd0);
        check("dis_code_kept", 64'(m4.code), 64'd3);
        step();
        check("dis_ignore_bcode", 64'(m4.bcode), 64'h0);
        check("dis_ignore_code",  64'(m4.code), 64'd3);
        m4.in_valid = 1'b0;
        m4.en = 1'b1; m4.mode = 1'b1; m4.dwell = 8'd0;
        step();
        check("reen_scan_bcode", 64'(m4.bcode), 64'h0008);
        step();
        check("reen_scan_step", 64'(m4.bcode), 64'h0010);
        m4.en = 1'b0;
        step();
        check("scan_dis_bcode",     64'(m4.bcode), 64'h0);
        check("scan_dis_out_valid", 64'(m4.out_valid), 64'd0);
        check("scan_dis_code",      64'(m4.code), 64'd4);

        // 6: async reset between edges mid-scan on all three widths, then restart at bit 0
        m4.en = 1'b1; m4.mode = 1'b1; m4.dwell = 8'd0;
        m2.en = 1'b1; m2.mode = 1'b1; m2.dwell = 8'd0;
        m6.en = 1'b1; m6.mode = 1'b1; m6.dwell = 8'd0;
        step(10);
        check("pre_rst_code_w4", 64'(m4.code), 64'd13);
        check("pre_rst_code_w2", 64'(m2.code), 64'd1);
        check("pre_rst_code_w6", 64'(m6.code), 64'd9);
        #2 rst_n = 1'b0;
        #1;
        check("arst_bcode_w4", 64'(m4.bcode), 64'h0);
        check("arst_bcode_w2", 64'(m2.bcode), 64'h0);
        check("arst_bcode_w6", 64'(m6.bcode), 64'h0);
        check("arst_valid_w4", 64'(m4.out_valid), 64'd0);
        check("arst_code_w6",  64'(m6.code), 64'd0);
        #2 rst_n = 1'b1;
        step();
        check("restart_bcode_w4", 64'(m4.bcode), 64'h1);
        check("restart_bcode_w2", 64'(m2.bcode), 64'h1);
        check("restart_bcode_w6", 64'(m6.bcode), 64'h1);
        step(3);
        check("w2_code3",  64'(m2.code), 64'd3);
        check("w2_nowrap", 64'(m2.wrap), 64'd0);
        step();
        check("w2_wrap_bcode", 64'(m2.bcode), 64'h1);
        check("w2_wrap",       64'(m2.wrap), 64'd1);
        check("w4_bcode_4",    64'(m4.bcode), 64'h0010);
        check("w6_bcode_4",    64'(m6.bcode), 64'h0010);
        check("w6_nowrap",     64'(m6.wrap), 64'd0);
        step();
        check("w2_wrap_pulse_end", 64'(m2.wrap), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
